// File: rtl/elevator_button_frontend.sv
// Debounces raw push-buttons and emits one set pulse per accepted press toward the request latches.
// One ebf_lane per button; the top-floor up and ground-floor down channels are permanently dead.
module ebf_lane #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = $clog2(DEB_CYCLES+1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic lit_i,
  output logic fire_o,
  output logic busy_o
);
  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q;
  logic             fire_q, fire_d;
  logic             s, last;

  assign s    = sync_q[1];
  assign last = (cnt_q == CNT_W'(DEB_CYCLES-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      fire_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fire_q  <= fire_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire_d  = 1'b0;
    case (state_q)
      IDLE: if (s) begin
        state_d = DEB_PRESS;
        cnt_d   = '0;
      end
      DEB_PRESS: begin
        if (!s) state_d = IDLE;
        else if (last) begin
          state_d = HELD;
          // A request that is already latched still completes the press, silently.
          fire_d  = !lit_i;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      HELD: if (!s) begin
        state_d = DEB_RELEASE;
        cnt_d   = '0;
      end
      DEB_RELEASE: begin
        if (s) state_d = HELD;
        else if (last) state_d = IDLE;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign fire_o = fire_q;
  assign busy_o = (state_q != IDLE);
endmodule

module elevator_button_frontend #(
  parameter int N_FLOORS   = 4,
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = $clog2(DEB_CYCLES+1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] raw_up,
  input  logic [N_FLOORS-1:0] raw_down,
  input  logic [N_FLOORS-1:0] raw_floor,
  input  logic [N_FLOORS-1:0] lit_up,
  input  logic [N_FLOORS-1:0] lit_down,
  input  logic [N_FLOORS-1:0] lit_floor,
  output logic [N_FLOORS-1:0] ext_up,
  output logic [N_FLOORS-1:0] ext_down,
  output logic [N_FLOORS-1:0] ext_floor,
  output logic                busy
);
  localparam int NCH = 3*N_FLOORS;

  // Channel order: up[0..N-1], down[0..N-1], floor[0..N-1]
  logic [NCH-1:0] raw_all, lit_all, fire_all, busy_all;
  logic           dead_unused;

  assign raw_all     = {raw_floor, raw_down, raw_up};
  assign lit_all     = {lit_floor, lit_down, lit_up};
  assign dead_unused = ^{raw_up[N_FLOORS-1], raw_down[0], lit_up[N_FLOORS-1], lit_down[0]};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    if (c == N_FLOORS-1 || c == N_FLOORS) begin : g_dead
      assign fire_all[c] = 1'b0;
      assign busy_all[c] = 1'b0;
    end else begin : g_live
      ebf_lane #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (raw_all[c]),
        .lit_i  (lit_all[c]),
        .fire_o (fire_all[c]),
        .busy_o (busy_all[c])
      );
    end
  end

  assign ext_up    = fire_all[N_FLOORS-1:0];
  assign ext_down  = fire_all[2*N_FLOORS-1:N_FLOORS];
  assign ext_floor = fire_all[NCH-1:2*N_FLOORS];
  assign busy      = |busy_all;
endmodule

// File: tb/tb_elevator_button_frontend.sv
// Directed scenarios for the button front end with hand-derived pulse timing (DEB_CYCLES=16).
module tb_elevator_button_frontend;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] raw_up, raw_down, raw_floor, lit_up, lit_down, lit_floor;
  logic [3:0] ext_up, ext_down, ext_floor;
  logic       busy;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  elevator_button_frontend #(.N_FLOORS(4), .DEB_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .raw_up(raw_up), .raw_down(raw_down), .raw_floor(raw_floor),
    .lit_up(lit_up), .lit_down(lit_down), .lit_floor(lit_floor),
    .ext_up(ext_up), .ext_down(ext_down), .ext_floor(ext_floor),
    .busy(busy)
  );

  // After tick k returns, outputs reflect edge k; inputs set now are first sampled by the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    raw_up = '0; raw_down = '0; raw_floor = '0;
    repeat (40) tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL settle_idle busy=%b want 0", busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    raw_up = '0; raw_down = '0; raw_floor = '0;
    lit_up = '0; lit_down = '0; lit_floor = '0;
    #12;
    total++;
    if ({ext_up, ext_down, ext_floor, busy} !== 13'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want 0", {ext_up, ext_down, ext_floor, busy});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clean_press();
    logic [3:0] exp;
    raw_floor = 4'b0100;
    for (int k = 0; k < 40; k++) begin
      tick();
      exp = (k == 18) ? 4'b0100 : 4'b0000;
      total++;
      if (ext_floor !== exp) begin bad++; $display("FAIL clean_press k=%0d ext_floor=%b want %b", k, ext_floor, exp); end
    end
    raw_floor = '0;
    for (int r = 0; r < 19; r++) begin
      tick();
      total++;
      if (ext_floor !== 4'b0000) begin bad++; $display("FAIL clean_release_pulse r=%0d ext_floor=%b", r, ext_floor); end
      if (r == 17 || r == 18) begin
        total++;
        if (busy !== (r == 17)) begin bad++; $display("FAIL clean_busy_fall r=%0d busy=%b want %b", r, busy, r == 17); end
      end
    end
    settle();
  endtask

  task automatic test_bounce_reject();
    for (int k = 0; k < 100; k++) begin
      raw_up[1] = ((k / 5) % 2) == 0;
      tick();
      total++;
      if (ext_up !== 4'b0000) begin bad++; $display("FAIL bounce_reject k=%0d ext_up=%b want 0000", k, ext_up); end
    end
    settle();
  endtask

  task automatic test_release_bounce();
    int npulse = 0;
    raw_down[3] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (k >= 30 && k < 42) raw_down[3] = ((k - 30) % 4) != 0;
      else raw_down[3] = 1'b1;
      tick();
      if (ext_down !== 4'b0000) begin
        npulse++;
        total++;
        if (ext_down !== 4'b1000 || k != 18) begin
          bad++; $display("FAIL release_bounce_pulse k=%0d ext_down=%b want 1000 at k=18", k, ext_down);
        end
      end
    end
    total++;
    if (npulse != 1) begin bad++; $display("FAIL release_bounce_count got=%0d want 1", npulse); end
    settle();
  endtask

  task automatic test_suppression();
    int npulse = 0;
    lit_floor = 4'b0010;
    raw_floor[1] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      total++;
      if (ext_floor !== 4'b0000) begin bad++; $display("FAIL suppress_pulse k=%0d ext_floor=%b want 0000", k, ext_floor); end
    end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL suppress_held busy=%b want 1", busy); end
    settle();
    lit_floor = 4'b0000;
    raw_floor[1] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (ext_floor !== 4'b0000) npulse++;
      if (k == 18) begin
        total++;
        if (ext_floor !== 4'b0010) begin bad++; $display("FAIL unsuppressed_pulse ext_floor=%b want 0010", ext_floor); end
      end
    end
    total++;
    if (npulse != 1) begin bad++; $display("FAIL unsuppressed_count got=%0d want 1", npulse); end
    settle();
  endtask

  task automatic test_dead_simul();
    logic [3:0] eu, ed;
    raw_up = 4'b1111; raw_down = 4'b1111;
    for (int k = 0; k < 30; k++) begin
      tick();
      eu = (k == 18) ? 4'b0111 : 4'b0000;
      ed = (k == 18) ? 4'b1110 : 4'b0000;
      total++;
      if (ext_up !== eu || ext_down !== ed) begin
        bad++; $display("FAIL dead_simul k=%0d up=%b down=%b want %b %b", k, ext_up, ext_down, eu, ed);
      end
    end
    settle();
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp;
    raw_floor = 4'b0001;
    repeat (13) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if ({ext_up, ext_down, ext_floor, busy} !== 13'd0) begin
      bad++; $display("FAIL reset_mid_outputs got=%h want 0", {ext_up, ext_down, ext_floor, busy});
    end
    repeat (3) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      exp = (k == 18) ? 4'b0001 : 4'b0000;
      total++;
      if (ext_floor !== exp) begin bad++; $display("FAIL reset_mid_latency k=%0d ext_floor=%b want %b", k, ext_floor, exp); end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_release_bounce();
    test_suppression();
    test_dead_simul();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
